// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor computing diff = a - b - bin, LSB first, using one
//   full-subtractor cell and a borrow flip-flop. Each operation takes WIDTH
//   SHIFT cycles plus one DONE cycle.
//
//   Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to add the ovf output,
//   the signed two's-complement overflow of a - b - bin.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  request, sampled only while ready=1
//   a      minuend, captured on the accepted start
//   b      subtrahend, captured on the accepted start
//   bin    borrow-in, captured on the accepted start
//   ready  high in IDLE
//   busy   high in SHIFT
//   done   one-cycle pulse in DONE
//   diff   result, held from DONE until the next accepted start
//   bout   final borrow-out, held with diff
//   ovf    (SERIAL_SUBTRACTOR_OVF_EN only) signed overflow, held with diff
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic ai;
    logic bi;
    logic d;
    logic br_next;

    // Single full-subtractor cell working on the current LSBs.
    always_comb begin
        ai      = a_sr[0];
        bi      = b_sr[0];
        d       = ai ^ bi ^ br;
        br_next = (~ai & bi) | (~(ai ^ bi) & br);
    end

    assign ready = (state == IDLE);
    assign busy  = (state == SHIFT);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        diff  <= '0;
                        bout  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf   <= 1'b0;
`endif
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    diff <= {d, diff[WIDTH-1:1]};
                    a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    br   <= br_next;
                    if (cnt == LAST) begin
                        // MSB step: ai/bi are the original operand MSBs here.
                        // cnt is left at LAST so it never wraps.
                        bout  <= br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf   <= (ai != bi) && (d != ai);
`endif
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
        exp_t   e;
        longint ua, ub, sa, sb_v, r;
        ua   = longint'(av);
        ub   = longint'(bv);
        sa   = longint'($signed(av));
        sb_v = longint'($signed(bv));
        r    = ua - ub - longint'(bv_in);
        e.d  = W'(r);
        e.bo = (ua < ub + longint'(bv_in));
        r    = sa - sb_v - longint'(bv_in);
        e.ov = (r > (longint'(1) <<< (W - 1)) - 1) || (r < -(longint'(1) <<< (W - 1)));
        return e;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("diff", diff, e.d);
                check("bout", bout, e.bo);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                check("ovf", ovf, e.ov);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 4 * W) begin
            tick();
            n++;
        end
        if (!ready) check("ready_timeout", 0, 1);
    endtask

    // Drive one operation in cycle 0 and check the handshake timeline.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
        exp_t e;
        wait_ready();
        e = model(av, bv, bv_in);
        a = av; b = bv; bin = bv_in; start = 1'b1;
        sb.push_back(e);
        tick();
        start = 1'b0;
        for (int i = 1; i <= W; i++) begin
            check("busy_in_shift", busy, 1);
            check("ready_in_shift", ready, 0);
            check("done_in_shift", done, 0);
            tick();
        end
        check("done_cycle", done, 1);
        check("busy_at_done", busy, 0);
        tick();
        check("done_one_cycle", done, 0);
        check("ready_after_done", ready, 1);
        check("diff_held", diff, e.d);
        check("bout_held", bout, e.bo);
    endtask

    initial begin
        exp_t e2;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        tick();
        tick();
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;
        tick();

        // Directed cases
        run_op(8'h3C, 8'h15, 1'b0);
        run_op(8'h00, 8'h01, 1'b0);
        run_op(8'h10, 8'h10, 1'b1);
        run_op(8'hFF, 8'h00, 1'b0);
        run_op(8'h80, 8'h01, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0);
        run_op(8'h00, 8'hFF, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1);

        // start held high through an operation with changing operands
        wait_ready();
        a = 8'h9A; b = 8'h3B; bin = 1'b1; start = 1'b1;
        sb.push_back(model(8'h9A, 8'h3B, 1'b1));
        tick();
        for (int i = 1; i <= W + 1; i++) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            if (i == W + 1) check("hold_done_cycle", done, 1);
            else check("hold_busy", busy, 1);
            tick();
        end
        check("hold_ready_c10", ready, 1);
        a = 8'h21; b = 8'h47; bin = 1'b0;
        e2 = model(8'h21, 8'h47, 1'b0);
        sb.push_back(e2);
        tick();
        start = 1'b0;
        for (int i = 11; i <= 18; i++) begin
            check("hold2_busy", busy, 1);
            tick();
        end
        check("hold2_done_c19", done, 1);
        tick();
        check("hold2_diff", diff, e2.d);

        // Reset in the middle of SHIFT
        wait_ready();
        a = 8'h3C; b = 8'h15; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("midrst_ready", ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_diff", diff, 0);
        check("midrst_bout", bout, 0);
        for (int i = 0; i < W + 2; i++) begin
            check("midrst_no_done", done, 0);
            tick();
        end
        run_op(8'h05, 8'h03, 1'b0);

        // A few random operations
        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom));
        end

        tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing diff = a - b - bin, one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the subtract counterpart to the team's ripple full-adder datapath, for area-constrained arithmetic where latency is acceptable. Operands are accepted with a start/ready handshake. A one-cycle done pulse flags the result.

Parameters:
WIDTH, 8, operand and result width in bits; legal values are WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when ready=1
a  input  WIDTH  minuend; captured on the accepted start
b  input  WIDTH  subtrahend; captured on the accepted start
bin  input  1  borrow-in; captured on the accepted start
ready  output  1  high only in IDLE
busy  output  1  high in SHIFT
done  output  1  one-cycle pulse in DONE
diff  output  WIDTH  result; held from DONE until the next accepted start
bout  output  1  final borrow-out; held together with diff

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. ready=1, busy=0, done=0, diff=0, bout=0. Shift registers, borrow and counter all cleared.
- Reset overrides everything, including mid-SHIFT. The operation in progress is discarded and no done pulse is issued.
- Full-subtractor cell on current LSBs ai, bi and borrow br:
  - d = ai^bi^br
  - br_next = (~ai&bi) | (~(ai^bi)&br)
- IDLE:
  - ready=1.
  - If start=1: load a_sr<=a, b_sr<=b, br<=bin, cnt<=0, diff<=0, bout<=0; go to SHIFT.
- SHIFT:
  - busy=1.
  - Each cycle: diff <= {d, diff[WIDTH-1:1]}; a_sr and b_sr shift right by 1; br<=br_next; cnt<=cnt+1.
  - When cnt==WIDTH-1, that cycle's bit is the MSB. Capture bout<=br_next and go to DONE.
- DONE:
  - done=1 for exactly one cycle, with diff and bout valid.
  - Next state is IDLE unconditionally.
- Latency: start high in cycle c gives SHIFT in cycles c+1..c+WIDTH and done high in cycle c+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start while busy=1 or done=1 is ignored. Operands are not re-sampled, and the current result is not disturbed.
- diff/bout are not valid during SHIFT; they hold partial values there. They keep the final value after DONE until the next accepted start clears them.
- Arithmetic is modulo 2^WIDTH. bout=1 iff the unsigned value a < b+bin.
- cnt is clog2(WIDTH) bits wide. It never wraps within an operation.

Optional Feature:
Macro SERIAL_SUBTRACTOR_OVF_EN.
- When defined: adds output port ovf (1 bit), the signed two's-complement overflow of a-b-bin.
  - Computed at the MSB step as ovf <= (a_msb != b_msb) && (d_msb != a_msb).
  - Reset value 0, cleared on an accepted start, and held alongside diff.
- When undefined: the ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
1. WIDTH=8, a=0x3C, b=0x15, bin=0, start pulse in cycle 0 -> busy in cycles 1-8; done in cycle 9 only; diff=0x27, bout=0; ready=1 from cycle 10.
2. a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. With the macro defined: ovf=0.
3. a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1. Then a=0xFF, b=0x00, bin=0 -> diff=0xFF, bout=0.
4. Macro defined: a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
5. start held high with new operands throughout cycles 1-9 of an operation -> first result unaffected. Next operation is accepted in cycle 10; its done appears in cycle 19.
6. rst=1 in cycle 4 of an operation -> next cycle ready=1, busy=0, diff=0, bout=0; no done pulse. A following start with a=0x05, b=0x03 -> diff=0x02, bout=0.
